// File: rtl/thermo_pattern_tx.sv
// Serial thermometer-code generator: accepts a ones count and shifts out an N-bit
// pattern, LSB first, whose low 'count' bits are set.
module thermo_pattern_tx #(
    parameter int unsigned N  = 7,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic          ready,
    output logic          bit_out,
    output logic          bit_valid,
    output logic [CW-1:0] idx,
    output logic          done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [CW-1:0] NCount  = CW'(N);
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    state_e        state_q;
    logic [CW-1:0] k_q;
    logic [CW-1:0] cnt_q;

    logic [CW-1:0] count_sat;
    logic [CW-1:0] k_next;

    // Counts above N would otherwise ask for more ones than the word can hold.
    assign count_sat = (count > NCount) ? NCount : count;
    assign k_next    = k_q + CW'(1);

    // All outputs are registered; each one is set up a cycle ahead of the state it reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            cnt_q     <= '0;
            ready     <= 1'b1;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            idx       <= '0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StShift;
                        cnt_q     <= count_sat;
                        k_q       <= '0;
                        ready     <= 1'b0;
                        bit_valid <= 1'b1;
                        idx       <= '0;
                        bit_out   <= ('0 < count_sat);
                    end
                end
                StShift: begin
                    if (k_q == LastIdx) begin
                        state_q   <= StDone;
                        bit_valid <= 1'b0;
                        bit_out   <= 1'b0;
                        idx       <= '0;
                        done      <= 1'b1;
                    end else begin
                        k_q     <= k_next;
                        idx     <= k_next;
                        bit_out <= (k_next < cnt_q);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    ready     <= 1'b1;
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    idx       <= '0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
